// File: rtl/dec_trigger_csr.sv
// dec_trigger_csr
//   Debug trigger CSR block: holds tselect plus tdata1 (mcontrol format) and
//   tdata2 for each trigger, decodes CSR writes, serves combinational CSR
//   reads and drives the trigger packets consumed by the LSU/IFU matchers.
//
// Ports
//   clk, rst_l        core clock, asynchronous active-low reset
//   dec_csr_wen       CSR write strobe (one write per cycle)
//   dec_csr_waddr     write address: 0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2
//   dec_csr_wrdata    write data
//   dec_csr_raddr     read address
//   dbg_mode          core is in debug mode
//   trigger_hit       per-trigger hit reported back through commit
//   trigger_pkt_any   per-trigger packet, bit layout of each entry:
//                       [TDATA_W+5] select  [TDATA_W+4] match
//                       [TDATA_W+3] store   [TDATA_W+2] load
//                       [TDATA_W+1] execute [TDATA_W]   m
//                       [TDATA_W-1:0] tdata2
//   trigger_action    1 = enter debug mode, 0 = breakpoint exception
//   trigger_chain     chain bits (odd triggers always 0)
//   csr_rddata        read data for dec_csr_raddr
//   csr_rd_hit        dec_csr_raddr is one of 0x7A0-0x7A2
module dec_trigger_csr #(
    parameter  int NUM_TRIG = 4,
    parameter  int TDATA_W  = 32,
    localparam int PKT_W    = TDATA_W + 6,
    localparam int TSEL_W   = $clog2(NUM_TRIG)
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic                               dec_csr_wen,
    input  logic [11:0]                        dec_csr_waddr,
    input  logic [TDATA_W-1:0]                 dec_csr_wrdata,
    input  logic [11:0]                        dec_csr_raddr,
    input  logic                               dbg_mode,
    input  logic [NUM_TRIG-1:0]                trigger_hit,
    output logic [NUM_TRIG-1:0][PKT_W-1:0]     trigger_pkt_any,
    output logic [NUM_TRIG-1:0]                trigger_action,
    output logic [NUM_TRIG-1:0]                trigger_chain,
    output logic [TDATA_W-1:0]                 csr_rddata,
    output logic                               csr_rd_hit
);

    localparam logic [11:0] ADDR_TSEL = 12'h7A0;
    localparam logic [11:0] ADDR_TD1  = 12'h7A1;
    localparam logic [11:0] ADDR_TD2  = 12'h7A2;

    logic [TSEL_W-1:0]                tselect_q, tselect_d;
    logic [NUM_TRIG-1:0]              dmode_q, dmode_d, hit_q, hit_d;
    logic [NUM_TRIG-1:0]              select_q, select_d, action_q, action_d;
    logic [NUM_TRIG-1:0]              chain_q, chain_d, match_q, match_d;
    logic [NUM_TRIG-1:0]              m_q, m_d, execute_q, execute_d;
    logic [NUM_TRIG-1:0]              store_q, store_d, load_q, load_d;
    logic [NUM_TRIG-1:0][TDATA_W-1:0] tdata2_q, tdata2_d;

    logic                             wr_tsel, wr_td1, wr_td2;
    logic [NUM_TRIG-1:0]              wr_tgt;   // trigger selected and not locked
    logic [NUM_TRIG-1:0][TDATA_W-1:0] tdata1_rd;

    always_comb begin
        wr_tsel   = dec_csr_wen && (dec_csr_waddr == ADDR_TSEL);
        wr_td1    = dec_csr_wen && (dec_csr_waddr == ADDR_TD1);
        wr_td2    = dec_csr_wen && (dec_csr_waddr == ADDR_TD2);

        tselect_d = tselect_q;
        // Out-of-range selects are dropped rather than truncated.
        if (wr_tsel && (dec_csr_wrdata < TDATA_W'(NUM_TRIG)))
            tselect_d = dec_csr_wrdata[TSEL_W-1:0];

        wr_tgt    = '0;
        dmode_d   = dmode_q;
        select_d  = select_q;
        action_d  = action_q;
        chain_d   = chain_q;
        match_d   = match_q;
        m_d       = m_q;
        execute_d = execute_q;
        store_d   = store_q;
        load_d    = load_q;
        tdata2_d  = tdata2_q;
        hit_d     = hit_q;
        for (int i = 0; i < NUM_TRIG; i++) begin
            // A debug-owned trigger (dmode) is only writable from debug mode.
            wr_tgt[i] = (tselect_q == TSEL_W'(i)) && !(dmode_q[i] && !dbg_mode);
            if (wr_td1 && wr_tgt[i]) begin
                dmode_d[i]   = dec_csr_wrdata[27] & dbg_mode;
                action_d[i]  = dec_csr_wrdata[12] & dec_csr_wrdata[27] & dbg_mode;
                chain_d[i]   = (i % 2 == 0) ? dec_csr_wrdata[11] : 1'b0;
                select_d[i]  = dec_csr_wrdata[19];
                match_d[i]   = dec_csr_wrdata[7];
                m_d[i]       = dec_csr_wrdata[6];
                execute_d[i] = dec_csr_wrdata[2];
                store_d[i]   = dec_csr_wrdata[1];
                load_d[i]    = dec_csr_wrdata[0];
            end
            // Hardware hit wins over a same-cycle software clear, lock or not.
            hit_d[i] = trigger_hit[i] |
                       ((wr_td1 && wr_tgt[i]) ? dec_csr_wrdata[20] : hit_q[i]);
            if (wr_td2 && wr_tgt[i])
                tdata2_d[i] = dec_csr_wrdata;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tselect_q <= '0;
            dmode_q   <= '0;
            hit_q     <= '0;
            select_q  <= '0;
            action_q  <= '0;
            chain_q   <= '0;
            match_q   <= '0;
            m_q       <= '0;
            execute_q <= '0;
            store_q   <= '0;
            load_q    <= '0;
            tdata2_q  <= '0;
        end else begin
            tselect_q <= tselect_d;
            dmode_q   <= dmode_d;
            hit_q     <= hit_d;
            select_q  <= select_d;
            action_q  <= action_d;
            chain_q   <= chain_d;
            match_q   <= match_d;
            m_q       <= m_d;
            execute_q <= execute_d;
            store_q   <= store_d;
            load_q    <= load_d;
            tdata2_q  <= tdata2_d;
        end
    end

    // Packet outputs; fire enables are masked in debug mode.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            trigger_pkt_any[i] = {select_q[i], match_q[i],
                                  store_q[i]   & m_q[i] & ~dbg_mode,
                                  load_q[i]    & m_q[i] & ~dbg_mode,
                                  execute_q[i] & m_q[i] & ~dbg_mode,
                                  m_q[i], tdata2_q[i]};
            tdata1_rd[i] = {4'h2, dmode_q[i], 6'b0, hit_q[i], select_q[i], 6'b0,
                            action_q[i], chain_q[i], 3'b0, match_q[i], m_q[i], 3'b0,
                            execute_q[i], store_q[i], load_q[i]};
        end
        trigger_action = action_q;
        trigger_chain  = chain_q;
    end

    always_comb begin
        csr_rddata = '0;
        csr_rd_hit = 1'b0;
        case (dec_csr_raddr)
            ADDR_TSEL: begin
                csr_rddata = {{(TDATA_W-TSEL_W){1'b0}}, tselect_q};
                csr_rd_hit = 1'b1;
            end
            ADDR_TD1: begin
                csr_rddata = tdata1_rd[tselect_q];
                csr_rd_hit = 1'b1;
            end
            ADDR_TD2: begin
                csr_rddata = tdata2_q[tselect_q];
                csr_rd_hit = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dec_trigger_csr.sv
module tb_dec_trigger_csr;

    localparam int PKT_W = 38;

    logic                  clk = 1'b1;
    logic                  rst_l = 1'b1;
    logic                  dec_csr_wen = 1'b0;
    logic [11:0]           dec_csr_waddr = '0;
    logic [31:0]           dec_csr_wrdata = '0;
    logic [11:0]           dec_csr_raddr = '0;
    logic                  dbg_mode = 1'b0;
    logic [3:0]            trigger_hit = '0;
    logic [3:0][PKT_W-1:0] trigger_pkt_any;
    logic [3:0]            trigger_action;
    logic [3:0]            trigger_chain;
    logic [31:0]           csr_rddata;
    logic                  csr_rd_hit;

    always #5 clk = ~clk;

    dec_trigger_csr dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .dec_csr_wen    (dec_csr_wen),
        .dec_csr_waddr  (dec_csr_waddr),
        .dec_csr_wrdata (dec_csr_wrdata),
        .dec_csr_raddr  (dec_csr_raddr),
        .dbg_mode       (dbg_mode),
        .trigger_hit    (trigger_hit),
        .trigger_pkt_any(trigger_pkt_any),
        .trigger_action (trigger_action),
        .trigger_chain  (trigger_chain),
        .csr_rddata     (csr_rddata),
        .csr_rd_hit     (csr_rd_hit)
    );

    typedef struct {
        logic [31:0]           rd;
        logic                  rd_hit;
        logic [3:0][PKT_W-1:0] pkt;
        logic [3:0]            act;
        logic [3:0]            chn;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each tdata1 kept as its architectural 32-bit image
    // (type field added on read), tdata2 as a plain word.
    logic [31:0] m_t1 [4];
    logic [31:0] m_t2 [4];
    logic [1:0]  m_tsel;

    function automatic exp_t predict(logic [11:0] raddr, logic dbg);
        exp_t e;
        logic [31:0] w;
        e.rd     = 32'h0;
        e.rd_hit = 1'b1;
        case (raddr)
            12'h7A0: e.rd = {30'b0, m_tsel};
            12'h7A1: e.rd = m_t1[m_tsel] | 32'h2000_0000;
            12'h7A2: e.rd = m_t2[m_tsel];
            default: e.rd_hit = 1'b0;
        endcase
        for (int i = 0; i < 4; i++) begin
            w = m_t1[i];
            e.pkt[i] = {w[19], w[7], w[1] & w[6] & ~dbg, w[0] & w[6] & ~dbg,
                        w[2] & w[6] & ~dbg, w[6], m_t2[i]};
            e.act[i] = w[12];
            e.chn[i] = w[11];
        end
        return e;
    endfunction

    task automatic model_write(logic wen, logic [11:0] waddr, logic [31:0] wd,
                               logic dbg, logic [3:0] hit);
        logic [1:0]  sel;
        logic        locked;
        logic [31:0] w;
        sel    = m_tsel;
        locked = m_t1[sel][27] && !dbg;
        if (wen) begin
            if (waddr == 12'h7A0 && wd <= 32'd3) m_tsel = wd[1:0];
            if (waddr == 12'h7A1 && !locked) begin
                w = wd & 32'h0018_18C7;
                if (dbg) w[27] = wd[27];
                if (!w[27]) w[12] = 1'b0;
                if (sel[0]) w[11] = 1'b0;
                m_t1[sel] = w;
            end
            if (waddr == 12'h7A2 && !locked) m_t2[sel] = wd;
        end
        for (int i = 0; i < 4; i++)
            if (hit[i]) m_t1[i][20] = 1'b1;
    endtask

    // One bus cycle: drive inputs, queue the outputs expected before the
    // next edge, then advance the model across that edge.
    task automatic cyc(logic wen, logic [11:0] waddr, logic [31:0] wd,
                       logic [11:0] raddr, logic dbg, logic [3:0] hit);
        dec_csr_wen    = wen;
        dec_csr_waddr  = waddr;
        dec_csr_wrdata = wd;
        dec_csr_raddr  = raddr;
        dbg_mode       = dbg;
        trigger_hit    = hit;
        q.push_back(predict(raddr, dbg));
        @(posedge clk);
        if (rst_l) model_write(wen, waddr, wd, dbg, hit);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("csr_rddata", 64'(csr_rddata), 64'(e.rd));
            chk("csr_rd_hit", 64'(csr_rd_hit), 64'(e.rd_hit));
            chk("trigger_action", 64'(trigger_action), 64'(e.act));
            chk("trigger_chain", 64'(trigger_chain), 64'(e.chn));
            for (int i = 0; i < 4; i++)
                chk($sformatf("pkt%0d", i), 64'(trigger_pkt_any[i]), 64'(e.pkt[i]));
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_t1[i] = '0;
            m_t2[i] = '0;
        end
        m_tsel = '0;
        #2 rst_l = 1'b0;

        // Reset state
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'hFFFF_FFFF, 12'h7A0, 1'b0, 4'h0);
        rst_l = 1'b1;
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A0, 1'b0, 4'h0);

        // Normal programming of trigger 2 (read-during-write sees old value)
        cyc(1'b1, 12'h7A0, 32'd2, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A2, 32'h8000_0010, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0000_0043, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A2, 1'b0, 4'h0);

        // Illegal tselect, and writes to 0x7A3-0x7A5
        cyc(1'b1, 12'h7A0, 32'd5, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A3, 32'hFFFF_FFFF, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A5, 32'hFFFF_FFFF, 12'h7A3, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);

        // Debug-mode lock on trigger 1
        cyc(1'b1, 12'h7A0, 32'd1, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0800_1000, 12'h7A1, 1'b1, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A2, 32'h1234_5678, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A2, 1'b0, 4'h0);

        // action without dmode on trigger 0
        cyc(1'b1, 12'h7A0, 32'd0, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0800_1000, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);

        // Chain masking: unlock trigger 1 from debug mode, then set chain on 0 and 1
        cyc(1'b1, 12'h7A0, 32'd1, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0, 12'h7A1, 1'b1, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0000_0800, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A0, 32'd0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0000_0800, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);

        // Sticky hit on trigger 3
        cyc(1'b1, 12'h7A0, 32'd3, 12'h7A0, 1'b0, 4'h0);
        cyc(1'b1, 12'h7A1, 32'h0000_0041, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'b1000);
        cyc(1'b1, 12'h7A1, 32'h0000_0041, 12'h7A1, 1'b0, 4'b1000);
        cyc(1'b1, 12'h7A1, 32'h0000_0041, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b1, 4'b0100);
        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [11:0] wa, ra;
            logic [31:0] wd;
            wa = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'h7A0 + 12'($urandom_range(0, 5));
            wd = (wa == 12'h7A0) ? 32'($urandom_range(0, 7)) : $urandom;
            ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'h7A0 + 12'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 1)), wa, wd, ra,
                $urandom_range(0, 3) == 0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end

        cyc(1'b0, 12'h0, 32'h0, 12'h7A1, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
